// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - write-back, write-allocate direct-mapped cache controller
// Owns valid/dirty/tag state and the line array; sequences misses via mem_req/mem_ack.
module cache_ctrl_fsm #(
  parameter int TAG_W  = 4,
  parameter int IDX_W  = 2,
  parameter int LINE_W = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [TAG_W+IDX_W+3:0]        cpu_addr,
  input  logic [7:0]                    cpu_wdata,
  output logic [31:0]                   cpu_rdata,
  output logic                          cpu_done,
  output logic                          cpu_hit,
  output logic                          cpu_busy,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [TAG_W+IDX_W+3:0]        mem_addr,
  output logic [LINE_W-1:0]             mem_wdata,
  input  logic [LINE_W-1:0]             mem_rdata,
  input  logic                          mem_ack
);

  localparam int ADDR_W = TAG_W + IDX_W + 4;
  localparam int NLINES = 2 ** IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    RESPOND
  } state_t;

  state_t                state_q, state_d;
  logic [NLINES-1:0]     valid_q, valid_d;
  logic [NLINES-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [NLINES];
  logic [TAG_W-1:0]      tag_d  [NLINES];
  logic [LINE_W-1:0]     line_q [NLINES];
  logic [LINE_W-1:0]     line_d [NLINES];
  logic                  req_we_q, req_we_d;
  logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
  logic [7:0]            req_wdata_q, req_wdata_d;
  logic                  first_q, first_d;
  logic                  first_hit_q, first_hit_d;
  logic [31:0]           cpu_rdata_q, cpu_rdata_d;
  logic                  cpu_done_q, cpu_done_d;
  logic                  cpu_hit_q, cpu_hit_d;

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [1:0]            req_word;
  logic [1:0]            req_byte;
  logic [6:0]            byte_lo;
  logic [6:0]            word_lo;
  logic [LINE_W-1:0]     cur_line;
  logic [LINE_W-1:0]     wr_line;
  logic                  hit;

  assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr_q[4 +: IDX_W];
  assign req_word = req_addr_q[3:2];
  assign req_byte = req_addr_q[1:0];

  // Big-endian within the line: word 0 / byte 0 sit at the top bits.
  assign word_lo = 7'd96 - {req_word, 5'b00000};
  assign byte_lo = 7'd120 - {req_word, 5'b00000} - {2'b00, req_byte, 3'b000};

  assign cur_line  = line_q[req_idx];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_hit   = cpu_hit_q;
  assign cpu_busy  = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    line_d      = line_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    first_d     = first_q;
    first_hit_d = first_hit_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_done_d  = 1'b0;
    cpu_hit_d   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    wr_line     = cur_line;
    if (req_we_q) begin
      wr_line[byte_lo +: 8] = req_wdata_q;
    end

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          first_d     = 1'b1;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        first_d = 1'b0;
        if (first_q) begin
          first_hit_d = hit;
        end
        if (hit) begin
          // The write and the response are registered together so RESPOND sees both.
          if (req_we_q) begin
            line_d[req_idx]  = wr_line;
            dirty_d[req_idx] = 1'b1;
          end
          cpu_rdata_d = wr_line[word_lo +: 32];
          cpu_done_d  = 1'b1;
          cpu_hit_d   = first_q ? hit : first_hit_q;
          state_d     = RESPOND;
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx], req_idx, 4'b0000};
        mem_wdata = cur_line;
        if (mem_ack) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, 4'b0000};
        if (mem_ack) begin
          line_d[req_idx]  = mem_rdata;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = COMPARE;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int i = 0; i < NLINES; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      first_q     <= 1'b0;
      first_hit_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      cpu_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      line_q      <= line_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      first_q     <= first_d;
      first_hit_q <= first_hit_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_done_q  <= cpu_done_d;
      cpu_hit_q   <= cpu_hit_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb/tb_cache_ctrl_fsm.sv - scoreboard bench for cache_ctrl_fsm
module tb_cache_ctrl_fsm;

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    int          cycles;
  } exp_t;

  typedef struct {
    logic         we;
    logic [9:0]   addr;
    logic [127:0] wdata;
  } mem_exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [9:0]   cpu_addr = '0;
  logic [7:0]   cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_done;
  logic         cpu_hit;
  logic         cpu_busy;
  logic         mem_req;
  logic         mem_we;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;

  int           n_checks = 0;
  int           n_pass = 0;
  int           edge_cnt = 0;
  int           lat = 3;
  int           mem_cnt = 0;
  logic         idle_ack = 1'b0;

  exp_t         exp_q[$];
  mem_exp_t     mem_q[$];
  int           sample_q[$];
  logic [127:0] mem [int];

  cache_ctrl_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_hit   (cpu_hit),
    .cpu_busy  (cpu_busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Response monitor: pops the scoreboard on every cpu_done pulse.
  always @(negedge clk) begin
    if (rst_n && cpu_req && !cpu_busy) sample_q.push_back(edge_cnt + 1);
    if (cpu_done) begin
      if (exp_q.size() == 0 || sample_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        int   s;
        e = exp_q.pop_front();
        s = sample_q.pop_front();
        check("cpu_rdata", cpu_rdata, e.rdata);
        check("cpu_hit", cpu_hit, e.hit);
        check("done_cycle", edge_cnt - s + 1, e.cycles);
      end
    end
  end

  // Memory model and transaction monitor.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst_n) begin
      mem_cnt = 0;
    end else if (idle_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = {4{32'hBADBAD00}};
    end else if (mem_req) begin
      mem_cnt++;
      if (mem_cnt >= lat) begin
        mem_cnt = 0;
        mem_ack = 1'b1;
        if (mem_q.size() == 0) begin
          check("unexpected_mem_txn", {mem_we, mem_addr}, 0);
        end else begin
          mem_exp_t m;
          m = mem_q.pop_front();
          check("mem_we", mem_we, m.we);
          check("mem_addr", mem_addr, m.addr);
          check("mem_wdata", mem_wdata, m.wdata);
        end
        if (mem_we) mem[int'(mem_addr)] = mem_wdata;
        else mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : '0;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  task automatic wait_done(output int done_edge);
    int k;
    k = 0;
    done_edge = -1;
    while (k < 80) begin
      @(negedge clk);
      if (cpu_done) begin
        done_edge = edge_cnt;
        break;
      end
      k++;
    end
    if (done_edge < 0) check("done_timeout", 0, 1);
  endtask

  task automatic issue(input logic [9:0] addr, input logic we, input logic [7:0] wd,
                       input logic [31:0] er, input logic eh, input int ec,
                       input logic hold, output int done_edge);
    exp_t e;
    e.rdata = er;
    e.hit = eh;
    e.cycles = ec;
    exp_q.push_back(e);
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_wdata = wd;
    cpu_req   = 1'b1;
    wait_done(done_edge);
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic push_mem(input logic we, input logic [9:0] addr, input logic [127:0] wd);
    mem_exp_t m;
    m.we = we;
    m.addr = addr;
    m.wdata = wd;
    mem_q.push_back(m);
  endtask

  initial begin
    int d, prev;
    mem[32'h3C0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    mem[32'h000] = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    mem[32'h010] = 128'h10111213_14151617_18191A1B_1C1D1E1F;
    mem[32'h020] = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    repeat (2) @(negedge clk);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cpu_done", cpu_done, 0);
    check("rst_cpu_hit", cpu_hit, 0);
    check("rst_cpu_busy", cpu_busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean miss, then hold check on cpu_rdata.
    lat = 3;
    push_mem(1'b0, 10'h3C0, '0);
    issue(10'h3C4, 1'b0, 8'h00, 32'h44556677, 1'b0, 6, 1'b0, d);
    @(negedge clk);
    check("rdata_hold", cpu_rdata, 32'h44556677);
    check("done_pulse_width", cpu_done, 0);

    // Write hit.
    issue(10'h3C5, 1'b1, 8'hA5, 32'h44A56677, 1'b1, 2, 1'b0, d);

    // Dirty eviction: write-back of 0x3C0 then fill from 0x000.
    push_mem(1'b1, 10'h3C0, 128'h00112233_44A56677_8899AABB_CCDDEEFF);
    push_mem(1'b0, 10'h000, '0);
    issue(10'h004, 1'b0, 8'h00, 32'h0B0A0908, 1'b0, 9, 1'b0, d);

    // Back-to-back reads with cpu_req held high.
    lat = 2;
    push_mem(1'b0, 10'h010, '0);
    issue(10'h010, 1'b0, 8'h00, 32'h10111213, 1'b0, 5, 1'b1, prev);
    issue(10'h014, 1'b0, 8'h00, 32'h14151617, 1'b1, 2, 1'b1, d);
    check("b2b_spacing_1", d - prev, 3);
    prev = d;
    issue(10'h018, 1'b0, 8'h00, 32'h18191A1B, 1'b1, 2, 1'b1, d);
    check("b2b_spacing_2", d - prev, 3);
    prev = d;
    issue(10'h01C, 1'b0, 8'h00, 32'h1C1D1E1F, 1'b1, 2, 1'b0, d);
    check("b2b_spacing_3", d - prev, 3);

    // Dirty the line at index 0, then reset in the middle of its write-back.
    issue(10'h001, 1'b1, 8'h77, 32'h0F770D0C, 1'b1, 2, 1'b0, d);
    lat = 5;
    push_mem(1'b1, 10'h000, 128'h0F770D0C_0B0A0908_07060504_03020100);
    exp_q.push_back('{rdata: 32'h0, hit: 1'b0, cycles: 0});
    cpu_addr = 10'h3C0;
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    d = 0;
    for (int k = 0; k < 40 && d < 2; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) d++;
    end
    check("wb_started", d, 2);
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rst_abort_mem_req", mem_req, 0);
    check("rst_abort_busy", cpu_busy, 0);
    rst_n = 1'b1;
    exp_q.delete();
    mem_q.delete();
    sample_q.delete();
    @(negedge clk);
    lat = 3;
    push_mem(1'b0, 10'h3C0, '0);
    issue(10'h3C0, 1'b0, 8'h00, 32'h00112233, 1'b0, 6, 1'b0, d);

    // Stray ack while idle, then an L=1 miss.
    @(negedge clk);
    @(posedge clk);
    idle_ack = 1'b1;
    @(posedge clk);
    idle_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_busy", cpu_busy, 0);
    check("idle_ack_mem_req", mem_req, 0);
    check("idle_ack_done", cpu_done, 0);
    lat = 1;
    push_mem(1'b0, 10'h020, '0);
    issue(10'h028, 1'b0, 8'h00, 32'h12345678, 1'b0, 4, 1'b0, d);

    repeat (4) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("mem_q_empty", mem_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
